// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Memory defaults, access direction encoding and the fetch buffer entry layout.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_STARTING_ADDR   = 32'h0100_0000;
  localparam logic [31:0] DEFAULT_MEM_DEPTH_BYTES = 32'h0010_0000;
  localparam logic [31:0] INST_BYTES              = 32'd4;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order fetch buffer of fetch_entry_t with a synchronous flush.
// The caller never pushes when full without a matching pop, and never pops when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic           flush,
  input  fetch_entry_t   wr_entry,
  output logic [CW-1:0]  count,
  output logic           full,
  output logic           empty,
  output fetch_entry_t   head
);

  fetch_entry_t    storage [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is carried
  // entirely by count, so clearing the data would only add reset fan-out.
  always_ff @(posedge clock) begin
    if (push) storage[wr_ptr] <= wr_entry;
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = storage[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// RV32 instruction fetch: PC register, fault detection and decode handshake around fetch_fifo.
// Define FETCH_BOUNDS_CHECK_EN to also fault on addresses outside main memory.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] STARTING_ADDR   = DEFAULT_STARTING_ADDR,
  parameter logic [31:0] MEM_DEPTH_BYTES = DEFAULT_MEM_DEPTH_BYTES,
  parameter int          FIFO_DEPTH      = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic        mem_read_write,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output logic        halted
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  // Upper bound computed in 33 bits so base + size cannot wrap past 2^32.
  localparam logic [32:0] LO_BOUND = {1'b0, STARTING_ADDR};
  localparam logic [32:0] HI_BOUND = {1'b0, STARTING_ADDR} + {1'b0, MEM_DEPTH_BYTES}
                                   - {1'b0, INST_BYTES};

  logic [31:0]   pc;
  logic          pop;
  logic          push_en;
  logic          misaligned;
  logic          out_of_range;
  logic          fault;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head;

  assign mem_address    = pc;
  assign mem_read_write = READ;
  assign mem_data_in    = '0;

  assign pop     = inst_valid && inst_ready;
  assign push_en = !halted && (!fifo_full || pop);

  assign misaligned   = (pc[1:0] != 2'b00);
  assign out_of_range = ({1'b0, pc} < LO_BOUND) || ({1'b0, pc} > HI_BOUND);
  assign fault        = misaligned || (BOUNDS_EN && out_of_range);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_entry = '{pc: pc, inst: mem_data_out, fault: 1'b0};
    if (fault) begin
      wr_entry.inst  = '0;
      wr_entry.fault = 1'b1;
    end
  end

  // Reset beats redirect, redirect beats fetch; a fault parks pc on the bad address.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc     <= STARTING_ADDR;
      halted <= 1'b0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      halted <= 1'b0;
    end else if (push_en) begin
      if (fault) halted <= 1'b1;
      else       pc     <= pc + INST_BYTES;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push_en && !redirect_valid),
    .pop      (pop && !redirect_valid),
    .flush    (redirect_valid),
    .wr_entry (wr_entry),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head)
  );

  assign inst_valid = !fifo_empty;
  assign inst       = inst_valid ? head.inst  : '0;
  assign inst_pc    = inst_valid ? head.pc    : '0;
  assign inst_fault = inst_valid ? head.fault : 1'b0;

  always_ff @(posedge clock) begin
    if (!reset) assert (fifo_count <= CW'(FIFO_DEPTH));
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: queue-based reference model plus directed literal checks.
// Honours FETCH_BOUNDS_CHECK_EN the same way the design does.
module tb_instr_fetch;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam logic [31:0] MEMSZ = 32'h0010_0000;
  localparam int          DEPTH = 2;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          fault;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mem_address;
  logic        mem_read_write;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        halted;

  int checks = 0;
  int errors = 0;

  exp_t        mq[$];
  logic [31:0] mpc   = BASE;
  bit          mhalt = 1'b0;

  always #5 clock = ~clock;

  // Memory contents: words 0x13, 0x17, ... 0x7F preloaded from BASE; elsewhere an address hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a >= BASE && off < 32'h70 && a[1:0] == 2'b00) return 32'h13 + off;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  assign mem_data_out = mem_word(mem_address);

  instr_fetch u_dut (
    .clock          (clock),
    .reset          (reset),
    .mem_address    (mem_address),
    .mem_read_write (mem_read_write),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .halted         (halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the buffer and pc must hold after each edge.
  always @(posedge clock) begin : model
    int  n;
    bit  p;
    bit  f;
    n = mq.size();
    p = (n > 0) && (inst_ready === 1'b1);
    if (reset) begin
      mq.delete();
      mpc   = BASE;
      mhalt = 1'b0;
    end else if (redirect_valid) begin
      mq.delete();
      mpc   = redirect_pc;
      mhalt = 1'b0;
    end else begin
      if (p) void'(mq.pop_front());
      if (!mhalt && (n < DEPTH || p)) begin
        f = (mpc % 4 != 0) ||
            (BOUNDS && (mpc < BASE || (64'(mpc) + 64'd4) > (64'(BASE) + 64'(MEMSZ))));
        if (f) begin
          mq.push_back('{pc: mpc, inst: 32'h0, fault: 1'b1});
          mhalt = 1'b1;
        end else begin
          mq.push_back('{pc: mpc, inst: mem_word(mpc), fault: 1'b0});
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  always @(negedge clock) begin : compare
    check("mem_address", mem_address, mpc);
    check("halted", 32'(halted), 32'(mhalt));
    check("inst_valid", 32'(inst_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("head_pc", inst_pc, mq[0].pc);
      check("head_inst", inst, mq[0].inst);
      check("head_fault", 32'(inst_fault), 32'(mq[0].fault));
    end
  end

  initial begin
    reset          = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(negedge clock);

    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_fault", 32'(inst_fault), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_mem_address", mem_address, 32'h0100_0000);
    check("mem_read_write", 32'(mem_read_write), 32'h0);
    check("mem_data_in", mem_data_in, 32'h0);

    // Sequential fetch with decode always ready.
    reset      = 1'b0;
    inst_ready = 1'b1;
    @(negedge clock);
    check("seq0_pc", inst_pc, 32'h0100_0000);
    check("seq0_inst", inst, 32'h0000_0013);
    @(negedge clock);
    check("seq1_pc", inst_pc, 32'h0100_0004);
    check("seq1_inst", inst, 32'h0000_0017);
    @(negedge clock);
    check("seq2_pc", inst_pc, 32'h0100_0008);
    check("seq2_inst", inst, 32'h0000_001B);

    // Backpressure from a fresh start.
    reset      = 1'b1;
    inst_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("bp_count", 32'(u_dut.u_fifo.count), 32'd2);
    check("bp_mem_address", mem_address, 32'h0100_0008);
    check("bp_head_pc", inst_pc, 32'h0100_0000);
    inst_ready = 1'b1;
    @(negedge clock);
    check("bp_rel0", inst_pc, 32'h0100_0004);
    @(negedge clock);
    check("bp_rel1", inst_pc, 32'h0100_0008);
    @(negedge clock);
    check("bp_rel2", inst_pc, 32'h0100_000C);

    // Redirect with a full buffer and a pop in the same cycle.
    inst_ready = 1'b0;
    @(negedge clock);
    check("redir_full", 32'(u_dut.u_fifo.count), 32'd2);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0040;
    @(negedge clock);
    redirect_valid = 1'b0;
    check("redir_flushed", 32'(inst_valid), 32'h0);
    @(negedge clock);
    check("redir_pc", inst_pc, 32'h0100_0040);
    check("redir_inst", inst, 32'h0000_0053);

    // Misaligned target faults once and halts.
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0042;
    @(negedge clock);
    redirect_valid = 1'b0;
    check("mis_empty", 32'(inst_valid), 32'h0);
    @(negedge clock);
    check("mis_pc", inst_pc, 32'h0100_0042);
    check("mis_inst", inst, 32'h0);
    check("mis_fault", 32'(inst_fault), 32'h1);
    check("mis_halted", 32'(halted), 32'h1);
    repeat (2) @(negedge clock);
    check("mis_count", 32'(u_dut.u_fifo.count), 32'd1);
    check("mis_addr_hold", mem_address, 32'h0100_0042);
    inst_ready = 1'b1;
    @(negedge clock);
    check("mis_drained", 32'(inst_valid), 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0000;
    @(negedge clock);
    redirect_valid = 1'b0;
    check("mis_unhalt", 32'(halted), 32'h0);
    @(negedge clock);
    check("mis_resume", inst_pc, 32'h0100_0000);

    // Upper edge of memory: last word is legal, the next one is out of range.
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h010F_FFFC;
    @(negedge clock);
    redirect_valid = 1'b0;
    @(negedge clock);
    check("hi_last_pc", inst_pc, 32'h010F_FFFC);
    check("hi_last_fault", 32'(inst_fault), 32'h0);
    check("hi_last_inst", inst, 32'h010F_FFFC ^ 32'h5A5A_5A5A);
    @(negedge clock);
    inst_ready = 1'b1;
    @(negedge clock);
    check("hi_over_pc", inst_pc, 32'h0110_0000);
    check("hi_over_fault", 32'(inst_fault), 32'(BOUNDS));
    check("hi_over_halted", 32'(halted), 32'(BOUNDS));

    // Just below memory base.
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h00FF_FFFC;
    @(negedge clock);
    redirect_valid = 1'b0;
    @(negedge clock);
    check("lo_pc", inst_pc, 32'h00FF_FFFC);
    check("lo_fault", 32'(inst_fault), 32'(BOUNDS));
    check("lo_halted", 32'(halted), 32'(BOUNDS));

    // Reset with a full buffer and a simultaneous redirect.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0000;
    @(negedge clock);
    redirect_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_full", 32'(u_dut.u_fifo.count), 32'd2);
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0040;
    @(negedge clock);
    check("mid_valid", 32'(inst_valid), 32'h0);
    check("mid_pc", mem_address, 32'h0100_0000);
    check("mid_halted", 32'(halted), 32'h0);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    @(negedge clock);
    check("mid_restart", inst_pc, 32'h0100_0000);
    repeat (3) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the RV32 core, sitting directly upstream of the byte-addressed main memory model. It owns the program counter and drives the memory address with reads only. It captures each returned 32-bit little-endian instruction word with its PC into a small buffer and presents the entries to decode over a valid/ready handshake. Taken branches and jumps redirect it, which flushes all buffered entries.

## Interface
- STARTING_ADDR, 'h01000000, reset PC and base byte address of main memory
- MEM_DEPTH_BYTES, 'h0100000, size of main memory in bytes; used only by the bounds check
- FIFO_DEPTH, 2, number of fetch buffer entries; must be at least 2
- clock  input  1  single clock for all state
- reset  input  1  synchronous, active-high; sampled on posedge clock
- mem_address  output  32  byte address to memory; always equals pc
- mem_read_write  output  1  constant 0 (READ); this block never writes
- mem_data_in  output  32  constant 0
- mem_data_out  input  32  instruction word for mem_address, valid combinationally in the same cycle
- redirect_valid  input  1  one-cycle pulse; a redirect occurs this cycle
- redirect_pc  input  32  redirect target byte address
- inst_valid  output  1  buffer head is valid
- inst_ready  input  1  decode accepts the head this cycle
- inst  output  32  head instruction word
- inst_pc  output  32  head PC
- inst_fault  output  1  head is a fault marker; inst is 0 when set
- halted  output  1  fetch stopped after a fault; cleared only by redirect or reset

## Operation
- State:
  - pc (32 bits)
  - halted flag
  - FIFO of {pc, inst, fault} entries with a count
- pop = inst_valid && inst_ready.
- push_en = !halted && (count < FIFO_DEPTH || pop).
- Normal push:
  - writes {pc, mem_data_out, 0}.
  - pc <= pc + 4, modulo 2^32 with no saturation.
- Fault check, applied to pc at push time. A fault exists when either:
  - pc[1:0] != 0 (misaligned), or
  - the bounds check fails (bounds check only under the macro).
- On a fault:
  - push {pc, 0, 1}.
  - halted <= 1.
  - pc holds its value.
- Redirect has the highest priority, above reset-free activity:
  - count <= 0.
  - pc <= redirect_pc.
  - halted <= 0.
  - No push happens that cycle; any pop that cycle is discarded with the flush.
- Simultaneous push and pop at full: legal. Count stays the same and the head advances.
- Entries leave the buffer in strict order. Head fields are stable while inst_valid=1 && inst_ready=0.

## Timing
- Reset values:
  - pc = STARTING_ADDR
  - count = 0, so inst_valid = 0
  - inst = 0, inst_pc = 0, inst_fault = 0
  - halted = 0
  - mem_address = STARTING_ADDR
- Fetch latency: the memory word is captured on the posedge where push_en is high, and inst_valid rises after that edge. The first instruction is visible one cycle after reset deasserts.
- Throughput: one instruction per cycle while inst_ready is held at 1.
- Backpressure: with inst_ready=0, exactly FIFO_DEPTH pushes occur, then pc and mem_address hold.
- Redirect: inst_valid=0 in the cycle after the redirect edge. The target's entry becomes valid one cycle later, so the redirect penalty is 2 cycles.
- Reset mid-operation overrides everything, including a redirect in the same cycle. The buffer is emptied in one edge.

## Configuration
- FETCH_BOUNDS_CHECK_EN defined:
  - An access faults if pc < STARTING_ADDR or pc > STARTING_ADDR + MEM_DEPTH_BYTES - 4.
  - The comparison is done in 33 bits so the upper-bound sum cannot wrap.
- FETCH_BOUNDS_CHECK_EN undefined:
  - Only misalignment faults.
  - Out-of-range addresses are fetched normally and whatever memory returns is pushed.

## Structure
- Shared package fetch_pkg holds:
  - STARTING_ADDR and MEM_DEPTH_BYTES defaults
  - READ=0 and WRITE=1 constants
  - INST_BYTES=4
  - typedef fetch_entry_t {pc[31:0], inst[31:0], fault}
- One sub-module, fetch_fifo:
  - parameterised on depth; storage is fetch_entry_t
  - signals: push, pop, flush, count, full, empty, head
  - registered storage with a synchronous flush
- The top level contains the pc register, the fault logic and the handshake glue.

## Test plan
- Sequential fetch: preload words 0x00000013 through 0x0000007F, reset, hold inst_ready=1.
  - inst_pc sequence 0x01000000, 0x01000004, 0x01000008 on consecutive cycles, starting one cycle after reset.
- Backpressure: hold inst_ready=0 for 5 cycles.
  - count=2, mem_address held at 0x01000008, head inst_pc 0x01000000 stable.
  - Release inst_ready: no entry lost or duplicated.
- Redirect with the buffer full and a pop in the same cycle, redirect_pc=0x01000040.
  - Next cycle inst_valid=0.
  - Following cycle inst_pc=0x01000040 with the preloaded word.
- Misaligned redirect to 0x01000042.
  - One entry {0x01000042, 0, fault=1}, then halted=1 and no further pushes.
  - Redirect to 0x01000000 clears halted and resumes.
- Bounds, with FETCH_BOUNDS_CHECK_EN defined:
  - Redirect to 0x010FFFFC: a normal entry, then a fault entry at pc 0x01100000.
  - Redirect to 0x00FFFFFC: an immediate fault.
  - With the macro undefined, both produce normal entries.
- Reset asserted mid-stream with the buffer full and redirect_valid=1.
  - Next cycle inst_valid=0, pc=0x01000000, halted=0.
